// File: rtl/data_cache.sv
// Direct-mapped write-back data cache: 8 blocks of 4 bytes, tag [7:5], index [4:2], offset [1:0].
// Hits are serviced combinationally; misses stall the cpu while a dirty victim is written back and the new block fetched.
module data_cache (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_t;

    state_t      state;
    state_t      next_state;

    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [2:0]  tag_mem  [8];
    logic [31:0] data_mem [8];

    logic [2:0]  addr_tag;
    logic [2:0]  addr_index;
    logic [1:0]  addr_offset;
    logic        request;
    logic        hit;
    logic        write_hit;
    logic        mem_busy_seen;
    logic        mem_done;

    logic        mem_read_next;
    logic        mem_write_next;
    logic [5:0]  mem_address_next;
    logic [31:0] mem_writedata_next;

    assign addr_tag    = ADDRESS[7:5];
    assign addr_index  = ADDRESS[4:2];
    assign addr_offset = ADDRESS[1:0];

    assign request   = READ | WRITE;
    assign hit       = valid[addr_index] && (tag_mem[addr_index] == addr_tag);
    // READ and WRITE together is serviced as a write.
    assign write_hit = WRITE && hit && (state == IDLE);

    // A transfer completes only once memory has been seen busy and then drops busy.
    assign mem_done = ((state == WRITE_BACK) || (state == FETCH)) && mem_busy_seen && !MEM_BUSYWAIT;

    assign READDATA = hit ? data_mem[addr_index][{addr_offset, 3'b000} +: 8] : 8'd0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request && !hit) begin
                    next_state = (valid[addr_index] && dirty[addr_index]) ? WRITE_BACK : FETCH;
                end
            end
            WRITE_BACK: begin
                if (mem_done) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (mem_done) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Memory-side outputs are computed for the state being entered and registered below.
    always_comb begin
        BUSYWAIT           = request && !((state == IDLE) && hit);
        mem_read_next      = 1'b0;
        mem_write_next     = 1'b0;
        mem_address_next   = MEM_ADDRESS;
        mem_writedata_next = MEM_WRITEDATA;
        case (next_state)
            WRITE_BACK: begin
                mem_write_next     = 1'b1;
                mem_address_next   = {tag_mem[addr_index], addr_index};
                mem_writedata_next = data_mem[addr_index];
            end
            FETCH: begin
                mem_read_next    = 1'b1;
                mem_address_next = ADDRESS[7:2];
            end
            default: begin
                mem_read_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= 6'd0;
            MEM_WRITEDATA <= 32'd0;
        end else begin
            MEM_READ      <= mem_read_next;
            MEM_WRITE     <= mem_write_next;
            MEM_ADDRESS   <= mem_address_next;
            MEM_WRITEDATA <= mem_writedata_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || (next_state != state)) begin
            mem_busy_seen <= 1'b0;
        end else if ((state == WRITE_BACK) || (state == FETCH)) begin
            mem_busy_seen <= mem_busy_seen | MEM_BUSYWAIT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= 8'd0;
            dirty <= 8'd0;
        end else if (state == UPDATE) begin
            valid[addr_index] <= 1'b1;
            dirty[addr_index] <= 1'b0;
        end else if (write_hit) begin
            dirty[addr_index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            data_mem[addr_index] <= MEM_READDATA;
            tag_mem[addr_index]  <= addr_tag;
        end else if (write_hit) begin
            data_mem[addr_index][{addr_offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a behavioural block memory that stays busy for a fixed number of edges per transfer.
module tb_data_cache;

    logic        clk;
    logic        reset;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    int tests_run;
    int tests_failed;

    logic [31:0] mem_block [64];
    int          mem_op;
    int          remaining;
    int          mem_lat;

    int          busy_cycles;
    logic [7:0]  rdata;
    logic        saw_rd;
    logic        saw_wr;
    logic [5:0]  rd_addr;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    int          both_high;

    data_cache dut (
        .CLK           (clk),
        .RESET         (reset),
        .READ          (read),
        .WRITE         (write),
        .ADDRESS       (address),
        .WRITEDATA     (writedata),
        .READDATA      (readdata),
        .BUSYWAIT      (busywait),
        .MEM_READ      (mem_read),
        .MEM_WRITE     (mem_write),
        .MEM_ADDRESS   (mem_address),
        .MEM_WRITEDATA (mem_writedata),
        .MEM_READDATA  (mem_readdata),
        .MEM_BUSYWAIT  (mem_busywait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory asserts busy when a new request appears and releases it mem_lat edges later.
    always @(posedge clk) begin
        #1;
        if (mem_write && mem_op != 2) begin
            mem_op       = 2;
            remaining    = mem_lat;
            mem_busywait = 1'b1;
            mem_block[mem_address] = mem_writedata;
        end else if (mem_read && !mem_write && mem_op != 1) begin
            mem_op       = 1;
            remaining    = mem_lat;
            mem_busywait = 1'b1;
        end else if (mem_op != 0 && (mem_read || mem_write)) begin
            if (remaining > 1) begin
                remaining = remaining - 1;
            end else if (mem_busywait) begin
                mem_busywait = 1'b0;
                if (mem_op == 1) mem_readdata = mem_block[mem_address];
            end
        end else begin
            mem_op       = 0;
            mem_busywait = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Holds a request until the cache releases BUSYWAIT, recording the memory traffic seen on the way.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        read        = rd;
        write       = wr;
        address     = addr;
        writedata   = wdata;
        busy_cycles = 0;
        saw_rd      = 1'b0;
        saw_wr      = 1'b0;
        rd_addr     = 6'h3f;
        wr_addr     = 6'h3f;
        wr_data     = 32'hdeadbeef;
        both_high   = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) both_high++;
            if (!busywait) break;
            busy_cycles++;
            if (mem_read) begin
                saw_rd  = 1'b1;
                rd_addr = mem_address;
            end
            if (mem_write && !saw_wr) begin
                saw_wr  = 1'b1;
                wr_addr = mem_address;
                wr_data = mem_writedata;
            end
            @(posedge clk);
            #1;
        end
        rdata = readdata;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mem_op       = 0;
        remaining    = 0;
        mem_lat      = 5;
        mem_busywait = 1'b0;
        mem_readdata = 32'd0;
        for (int i = 0; i < 64; i++) mem_block[i] = 32'd0;
        mem_block[6'h00] = 32'h44332211;
        mem_block[6'h08] = 32'h88776655;
        mem_block[6'h01] = 32'hDDCCBBAA;
        mem_block[6'h09] = 32'h12345678;

        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = 8'd0;
        writedata = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset_mem_write", 32'(mem_write), 32'd0);
        checkOutput("reset_mem_address", 32'(mem_address), 32'd0);
        checkOutput("reset_mem_writedata", mem_writedata, 32'd0);
        checkOutput("reset_busywait", 32'(busywait), 32'd0);
        checkOutput("reset_readdata", 32'(readdata), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("clean_miss_busy", busy_cycles, 8);
        checkOutput("clean_miss_fetch", 32'(saw_rd), 32'd1);
        checkOutput("clean_miss_fetch_addr", 32'(rd_addr), 32'h00);
        checkOutput("clean_miss_no_wb", 32'(saw_wr), 32'd0);
        checkOutput("clean_miss_data", 32'(rdata), 32'h11);

        applyStimulus(1'b1, 1'b0, 8'h03, 8'h00);
        checkOutput("read_hit_busy", busy_cycles, 0);
        checkOutput("read_hit_no_fetch", 32'(saw_rd), 32'd0);
        checkOutput("read_hit_data", 32'(rdata), 32'h44);

        applyStimulus(1'b0, 1'b1, 8'h01, 8'hAA);
        checkOutput("write_hit_busy", busy_cycles, 0);
        applyStimulus(1'b1, 1'b0, 8'h01, 8'h00);
        checkOutput("write_hit_readback", 32'(rdata), 32'hAA);

        applyStimulus(1'b1, 1'b0, 8'h20, 8'h00);
        checkOutput("dirty_miss_busy", busy_cycles, 14);
        checkOutput("dirty_miss_wb_addr", 32'(wr_addr), 32'h00);
        checkOutput("dirty_miss_wb_data", wr_data, 32'h4433AA11);
        checkOutput("dirty_miss_fetch_addr", 32'(rd_addr), 32'h08);
        checkOutput("dirty_miss_both_high", both_high, 0);
        checkOutput("dirty_miss_data", 32'(rdata), 32'h55);

        applyStimulus(1'b1, 1'b0, 8'h01, 8'h00);
        checkOutput("refill_clean_busy", busy_cycles, 8);
        checkOutput("refill_clean_no_wb", 32'(saw_wr), 32'd0);
        checkOutput("refill_wb_data", 32'(rdata), 32'hAA);

        read    = 1'b1;
        address = 8'h40;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_fetch_mem_read", 32'(mem_read), 32'd1);
        checkOutput("mid_fetch_addr", 32'(mem_address), 32'h10);
        @(posedge clk);
        #1;
        reset = 1'b0;
        read  = 1'b0;
        @(negedge clk);
        checkOutput("reset_abort_mem_read", 32'(mem_read), 32'd0);
        checkOutput("reset_abort_state", 32'(dut.state), 32'd0);
        checkOutput("reset_abort_busywait", 32'(busywait), 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
        checkOutput("post_reset_miss_busy", busy_cycles, 8);
        checkOutput("post_reset_miss_fetch", 32'(saw_rd), 32'd1);
        checkOutput("post_reset_miss_data", 32'(rdata), 32'h11);

        applyStimulus(1'b1, 1'b0, 8'h04, 8'h00);
        checkOutput("blk1_fill_busy", busy_cycles, 8);
        checkOutput("blk1_fill_data", 32'(rdata), 32'hAA);
        applyStimulus(1'b1, 1'b1, 8'h04, 8'h5C);
        checkOutput("rw_both_busy", busy_cycles, 0);
        applyStimulus(1'b1, 1'b0, 8'h04, 8'h00);
        checkOutput("rw_both_readback", 32'(rdata), 32'h5C);
        applyStimulus(1'b1, 1'b0, 8'h24, 8'h00);
        checkOutput("rw_both_dirty_busy", busy_cycles, 14);
        checkOutput("rw_both_wb_addr", 32'(wr_addr), 32'h01);
        checkOutput("rw_both_wb_data", wr_data, 32'hDDCCBB5C);
        checkOutput("rw_both_fetch_addr", 32'(rd_addr), 32'h09);
        checkOutput("rw_both_new_data", 32'(rdata), 32'h78);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back data cache between the cpu data port (READ_MEMORY/WRITE_MEMORY, ADDRESS, WRITEDATA, READDATA, BUSYWAIT) and the block-wide data memory. Read and write hits complete without stalling. On a miss the cache holds the cpu with BUSYWAIT while it writes back a dirty victim block, then fetches the new block.

## Interface
Parameters
- none. Geometry is fixed: 8 blocks of 4 bytes. ADDRESS splits as tag [7:5], index [4:2], offset [1:0].

Ports
- CLK  in  1  clock. All state changes on posedge.
- RESET  in  1  synchronous, active-high.
- READ  in  1  cpu byte read request.
- WRITE  in  1  cpu byte write request.
- ADDRESS  in  8  cpu byte address.
- WRITEDATA  in  8  cpu store byte.
- READDATA  out  8  load byte. Combinational from the indexed block on a hit; 0 otherwise.
- BUSYWAIT  out  1  stall to the cpu. Combinational.
- MEM_READ  out  1  block fetch request. Registered.
- MEM_WRITE  out  1  block write-back request. Registered.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  victim block; byte 0 in [7:0].
- MEM_READDATA  in  32  fetched block; byte 0 in [7:0].
- MEM_BUSYWAIT  in  1  memory busy.

## Operation
- Storage per block: valid, dirty, 3-bit tag, 32-bit data.
- Hit is combinational: valid[index] && tag[index] == ADDRESS[7:5].
- Request = READ | WRITE. READ and WRITE both high is illegal; the cache treats it as WRITE.
- BUSYWAIT = request && !(state == IDLE && hit).
- Read hit: READDATA = data[index] byte selected by offset. No state change.
- Write hit: the byte at offset is replaced at the posedge in IDLE and dirty[index] is set to 1.
- FSM states: IDLE, WRITE_BACK, FETCH, UPDATE.
  - IDLE: on request && !hit, go to WRITE_BACK if valid && dirty, else go to FETCH.
  - WRITE_BACK: MEM_WRITE=1, MEM_ADDRESS={tag[index], index}, MEM_WRITEDATA=data[index]. On completion go to FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]. On completion go to UPDATE.
  - UPDATE: data[index]=MEM_READDATA, tag=ADDRESS[7:5], valid=1, dirty=0; go to IDLE. The request then hits and is serviced by the normal hit path.
- Memory completion: the first posedge in a transfer state where MEM_BUSYWAIT is sampled low, having been sampled high at least once earlier in that state. MEM_READ and MEM_WRITE stay asserted until that completion edge; they are never both high.
- The cpu holds READ, WRITE, ADDRESS and WRITEDATA stable while BUSYWAIT is high; the cache uses the live ADDRESS in every state.
- Reset: all valid and dirty bits are cleared and state goes to IDLE. Data and tag contents are don't-care.

## Timing
- Reset values after the reset edge: state IDLE, MEM_READ 0, MEM_WRITE 0, MEM_ADDRESS 0, MEM_WRITEDATA 0. BUSYWAIT is 0 with no request. READDATA is 0.
- Reset mid-miss: at the reset edge the cache abandons the transfer and drops MEM_READ and MEM_WRITE. Dirty data is lost.
- Hit: 0 stall cycles. A read hit's data is valid in the same cycle; a write hit is applied at the end of the request cycle.
- Clean miss: BUSYWAIT is high for 1 (IDLE) + F (FETCH cycles, ≥2) + 1 (UPDATE) cycles. It falls combinationally in the next IDLE cycle.
- Dirty miss: adds W (WRITE_BACK cycles, ≥2) before FETCH.
- A request that arrives during UPDATE→IDLE is treated like any IDLE request; there is no carried-over state.
- MEM_ADDRESS and MEM_WRITEDATA are held constant for the whole transfer.

## Test plan
- Reset then read 0x00, memory returns block 0x44332211 after 5 busy cycles → MEM_READ high with MEM_ADDRESS 0x00, BUSYWAIT high for 8 cycles total, then READDATA = 0x11.
- Read 0x03 immediately after the previous case → hit, BUSYWAIT never rises, READDATA = 0x44, MEM_READ stays 0.
- Write 0xAA to 0x01 (hit) → no stall. Block 0 becomes 0x4433AA11 with dirty = 1; a subsequent read of 0x01 returns 0xAA.
- Read 0x20 (same index, tag 1) with block 0 dirty → WRITE_BACK with MEM_ADDRESS 0x00 and MEM_WRITEDATA 0x4433AA11, then FETCH with MEM_ADDRESS 0x08, then UPDATE; the new block's dirty bit is 0.
- RESET asserted in the second FETCH cycle → MEM_READ is 0 after the reset edge and state is IDLE; the next read of 0x00 misses again (valid cleared).
- READ and WRITE both high, writing 0x5C to 0x04 after fill → handled as a write; block 1 byte 0 = 0x5C and dirty is set.
